// File: rtl/llc_input_arbiter.sv
// ---------------------------------------------------------------------------
// llc_input_arbiter
//
// Picks which inbound LLC channel enters the single-issue LLC pipeline next
// and holds that grant until the pipeline retires the transaction.
//
// Handshake: each channel presents *_valid; the arbiter drives the matching
// *_ready high combinationally for exactly one cycle when that channel wins
// in IDLE with pipe_idle set. A transfer happens on valid & ready in that
// cycle. Ready is never raised for a channel whose valid is low, and it is
// never raised while a transaction is in flight.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rsp_in_valid/ready       coherence response channel (highest priority)
//   rst_tb_valid/ready       testbench reset/flush channel
//   req_in_valid/ready       CPU request channel
//   dma_req_in_valid/ready   DMA request channel
//   req_stall                masks req_in
//   rst_stall                masks req_in and dma_req_in
//   flush_stall              masks dma_req_in
//   recall_pending           only rsp_in may be granted
//   pipe_idle                pipeline can accept a new transaction
//   pipe_done                one-cycle pulse, current transaction retired
//   sel_valid                transaction in flight (mirrors FSM BUSY)
//   sel_src                  0 rsp, 1 rst_tb, 2 req, 3 dma
//   starve_cnt               rounds req/dma have lost since their last grant
// ---------------------------------------------------------------------------
module llc_input_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsp_in_valid,
    output logic             rsp_in_ready,
    input  logic             rst_tb_valid,
    output logic             rst_tb_ready,
    input  logic             req_in_valid,
    output logic             req_in_ready,
    input  logic             dma_req_in_valid,
    output logic             dma_req_in_ready,
    input  logic             req_stall,
    input  logic             rst_stall,
    input  logic             flush_stall,
    input  logic             recall_pending,
    input  logic             pipe_idle,
    input  logic             pipe_done,
    output logic             sel_valid,
    output logic [1:0]       sel_src,
    output logic [CNT_W-1:0] starve_cnt
);

    // The starvation counter saturates at STARVE_LIMIT, so it must fit.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2 ** CNT_W) - 1) begin : g_limit_check
        $error("llc_input_arbiter: STARVE_LIMIT must be in 1..2**CNT_W-1");
    end

    localparam logic [1:0]       SRC_RSP = 2'd0;
    localparam logic [1:0]       SRC_RST = 2'd1;
    localparam logic [1:0]       SRC_REQ = 2'd2;
    localparam logic [1:0]       SRC_DMA = 2'd3;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_q;
    logic             sel_valid_q;
    logic [1:0]       sel_src_q;
    logic [CNT_W-1:0] starve_cnt_q;
    logic             rr_ptr_q;      // 0: req preferred, 1: dma preferred

    logic       e_rsp, e_rst, e_req, e_dma, e_rd;
    logic       override;
    logic       grant;
    logic [1:0] rd_src_d;
    logic [1:0] win_src_d;

    always_comb begin
        e_rsp = rsp_in_valid;
        e_rst = rst_tb_valid & ~recall_pending;
        e_req = req_in_valid & ~req_stall & ~rst_stall & ~recall_pending;
        e_dma = dma_req_in_valid & ~rst_stall & ~flush_stall & ~recall_pending;
        e_rd  = e_req | e_dma;

        // Round-robin only matters when both are eligible; a lone one wins.
        rd_src_d = SRC_REQ;
        if (e_req && e_dma) begin
            rd_src_d = rr_ptr_q ? SRC_DMA : SRC_REQ;
        end else if (e_dma) begin
            rd_src_d = SRC_DMA;
        end

        // A starved req/dma pair jumps ahead of rsp and rst_tb. Because
        // recall_pending clears e_rd, recall resolution is never blocked.
        override = (starve_cnt_q == LIMIT) && e_rd;

        win_src_d = SRC_RSP;
        if (override) begin
            win_src_d = rd_src_d;
        end else if (e_rsp) begin
            win_src_d = SRC_RSP;
        end else if (e_rst) begin
            win_src_d = SRC_RST;
        end else if (e_rd) begin
            win_src_d = rd_src_d;
        end

        // Gated by rst so readies read 0 while reset is held.
        grant = ~rst && (state_q == S_IDLE) && pipe_idle && (e_rsp | e_rst | e_rd);
    end

    assign rsp_in_ready     = grant && (win_src_d == SRC_RSP);
    assign rst_tb_ready     = grant && (win_src_d == SRC_RST);
    assign req_in_ready     = grant && (win_src_d == SRC_REQ);
    assign dma_req_in_ready = grant && (win_src_d == SRC_DMA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_valid_q  <= 1'b0;
            sel_src_q    <= SRC_RSP;
            starve_cnt_q <= '0;
            rr_ptr_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        state_q     <= S_BUSY;
                        sel_valid_q <= 1'b1;
                        sel_src_q   <= win_src_d;
                        if (win_src_d[1]) begin
                            // req/dma granted: point at the other one next.
                            starve_cnt_q <= '0;
                            rr_ptr_q     <= (win_src_d == SRC_REQ);
                        end else if (e_rd && starve_cnt_q != LIMIT) begin
                            starve_cnt_q <= starve_cnt_q + 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (pipe_done) begin
                        state_q     <= S_IDLE;
                        sel_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    sel_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sel_valid  = sel_valid_q;
    assign sel_src    = sel_src_q;
    assign starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_llc_input_arbiter.sv
// ---------------------------------------------------------------------------
// tb_llc_input_arbiter
//
// Directed bench. Each expected grant source is queued before the stimulus
// that should produce it; a monitor pops and compares on every ready pulse,
// and also checks readies are one-hot with a bubble between pulses.
// ---------------------------------------------------------------------------
module tb_llc_input_arbiter;

    logic       clk;
    logic       rst;
    logic       rsp_in_valid, rsp_in_ready;
    logic       rst_tb_valid, rst_tb_ready;
    logic       req_in_valid, req_in_ready;
    logic       dma_req_in_valid, dma_req_in_ready;
    logic       req_stall, rst_stall, flush_stall, recall_pending;
    logic       pipe_idle, pipe_done;
    logic       sel_valid;
    logic [1:0] sel_src;
    logic [3:0] starve_cnt;

    logic       any_ready;
    logic [1:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    llc_input_arbiter #(
        .STARVE_LIMIT(8),
        .CNT_W(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rsp_in_valid     (rsp_in_valid),
        .rsp_in_ready     (rsp_in_ready),
        .rst_tb_valid     (rst_tb_valid),
        .rst_tb_ready     (rst_tb_ready),
        .req_in_valid     (req_in_valid),
        .req_in_ready     (req_in_ready),
        .dma_req_in_valid (dma_req_in_valid),
        .dma_req_in_ready (dma_req_in_ready),
        .req_stall        (req_stall),
        .rst_stall        (rst_stall),
        .flush_stall      (flush_stall),
        .recall_pending   (recall_pending),
        .pipe_idle        (pipe_idle),
        .pipe_done        (pipe_done),
        .sel_valid        (sel_valid),
        .sel_src          (sel_src),
        .starve_cnt       (starve_cnt)
    );

    assign any_ready = rsp_in_ready | rst_tb_ready | req_in_ready | dma_req_in_ready;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic prev_any;
    initial prev_any = 1'b0;

    always @(negedge clk) begin
        logic [1:0] got;
        logic [1:0] want;
        if (any_ready) begin
            got = rsp_in_ready ? 2'd0 : rst_tb_ready ? 2'd1 : req_in_ready ? 2'd2 : 2'd3;
            chk("ready_onehot", $countones({rsp_in_ready, rst_tb_ready,
                                            req_in_ready, dma_req_in_ready}), 1);
            chk("ready_bubble", int'(prev_any), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", int'(got), 99);
            end else begin
                want = exp_q.pop_front();
                chk("grant_src", int'(got), int'(want));
            end
        end
        prev_any = any_ready;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect one grant right away, let it run one BUSY cycle, retire it.
    // Returns at posedge+1 of the IDLE cycle after retirement.
    task automatic grant_round(input logic [1:0] src, input int cnt_after);
        int lat;
        lat = -1;
        exp_q.push_back(src);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) chk("idle_sel_valid", int'(sel_valid), 0);
            if (any_ready) begin
                lat = i;
                break;
            end
            tick();
        end
        chk("grant_latency", lat, 0);
        if (lat >= 0) begin
            tick();
            pipe_done = 1'b1;
            @(negedge clk);
            chk("busy_sel_valid", int'(sel_valid), 1);
            chk("busy_sel_src", int'(sel_src), int'(src));
            chk("busy_starve_cnt", int'(starve_cnt), cnt_after);
            tick();
            pipe_done = 1'b0;
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk(name, int'(any_ready), 0);
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        rsp_in_valid = 0; rst_tb_valid = 0; req_in_valid = 0; dma_req_in_valid = 0;
        req_stall = 0; rst_stall = 0; flush_stall = 0; recall_pending = 0;
        pipe_idle = 1'b1; pipe_done = 1'b0;

        // Reset values.
        @(negedge clk);
        chk("rst_sel_valid", int'(sel_valid), 0);
        chk("rst_sel_src", int'(sel_src), 0);
        chk("rst_starve_cnt", int'(starve_cnt), 0);
        chk("rst_readies", int'(any_ready), 0);
        tick();
        rst = 1'b0;

        // Fixed priority with all four valid, then round-robin req/dma.
        rsp_in_valid = 1; rst_tb_valid = 1; req_in_valid = 1; dma_req_in_valid = 1;
        grant_round(2'd0, 1);
        rsp_in_valid = 0;
        grant_round(2'd1, 2);
        rst_tb_valid = 0;
        grant_round(2'd2, 0);
        grant_round(2'd3, 0);
        grant_round(2'd2, 0);
        grant_round(2'd3, 0);
        req_in_valid = 0; dma_req_in_valid = 0;

        // Starvation: rsp wins 8 rounds, then req overrides.
        rsp_in_valid = 1; req_in_valid = 1;
        for (int k = 1; k <= 8; k++) grant_round(2'd0, k);
        grant_round(2'd2, 0);
        rsp_in_valid = 0; req_in_valid = 0;

        // Recall pending: only rsp is eligible.
        recall_pending = 1; req_in_valid = 1; dma_req_in_valid = 1; rst_tb_valid = 1;
        expect_quiet("recall_no_ready", 20);
        rsp_in_valid = 1;
        grant_round(2'd0, 0);
        rsp_in_valid = 0; recall_pending = 0; rst_tb_valid = 0;

        // req_stall masks req only.
        req_stall = 1;
        grant_round(2'd3, 0);
        req_stall = 0;

        // rst_stall masks req and dma, rst_tb still granted.
        rst_stall = 1; rst_tb_valid = 1;
        grant_round(2'd1, 0);
        rst_tb_valid = 0;
        expect_quiet("rst_stall_no_ready", 4);

        // pipe_done in IDLE is ignored.
        pipe_done = 1;
        @(negedge clk);
        chk("idle_done_sel_valid", int'(sel_valid), 0);
        tick();
        pipe_done = 0;
        @(negedge clk);
        chk("idle_done_sel_valid2", int'(sel_valid), 0);
        chk("idle_done_sel_src", int'(sel_src), 1);
        tick();
        rst_stall = 0;
        grant_round(2'd2, 0);

        // pipe_idle low holds off grants.
        pipe_idle = 0;
        expect_quiet("pipe_busy_no_ready", 5);
        pipe_idle = 1;
        grant_round(2'd3, 0);
        req_in_valid = 0; dma_req_in_valid = 0;

        // Reset in the middle of a req transaction.
        rsp_in_valid = 1; req_in_valid = 1;
        grant_round(2'd0, 1);
        rsp_in_valid = 0;
        exp_q.push_back(2'd2);
        @(negedge clk);
        chk("mid_grant_req", int'(req_in_ready), 1);
        tick();
        dma_req_in_valid = 1;
        @(negedge clk);
        chk("mid_busy_sel_valid", int'(sel_valid), 1);
        chk("mid_busy_sel_src", int'(sel_src), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_sel_valid", int'(sel_valid), 0);
        chk("mid_rst_sel_src", int'(sel_src), 0);
        chk("mid_rst_starve_cnt", int'(starve_cnt), 0);
        chk("mid_rst_readies", int'(any_ready), 0);
        tick();
        rst = 1'b0;
        grant_round(2'd2, 0);
        req_in_valid = 0; dma_req_in_valid = 0;

        expect_quiet("tail_quiet", 2);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall watchdog so the run always ends.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
